// File: rtl/argmax_stream_m_t.sv
// ---------------------------------------------------------------------------
// argmax_stream_m_t
//
// Classification head placed after the last fc_* layer. It takes the
// layer's M-element signed output vector one element per valid/ready
// handshake. For each vector it returns the index of the largest element
// and that element's value.
//
// Ports
//   clk           clock, all logic on the rising edge
//   reset         asynchronous, active-high; clears all state
//   input_valid   upstream element valid
//   input_ready   block can accept an element (registered)
//   input_data    signed T-bit element
//   output_valid  result valid; held until output_ready
//   output_ready  downstream accepts the result
//   output_index  index of the maximum element (0 = first received)
//   output_max    signed value of the maximum element
//
// Configuration macro
//   ARGMAX_TIE_LAST_EN  undefined: strict compare, so ties keep the lowest
//                       index. Defined: >= compare, so ties move to the
//                       highest index. Ports and timing do not change.
// ---------------------------------------------------------------------------
module argmax_stream_m_t #(
  parameter  int M     = 16,
  parameter  int T     = 16,
  localparam int IDX_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [T-1:0]     input_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [IDX_W-1:0] output_index,
  output logic [T-1:0]     output_max
);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

  state_t           state_q,   state_d;
  logic [IDX_W-1:0] count_q,   count_d;
  logic             ready_q,   ready_d;
  logic             valid_q,   valid_d;
  logic [T-1:0]     run_max_q, run_max_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [T-1:0]     out_max_q, out_max_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  logic             in_hs;
  logic             out_hs;
  logic             take_new;
  logic [T-1:0]     cand_max;
  logic [IDX_W-1:0] cand_idx;

  // Candidate running maximum after the element currently offered. The
  // first element of a vector always wins; later ones win on the signed
  // compare. The final element's candidate feeds the result registers
  // directly so it is included in the compare.
  always_comb begin
    in_hs  = input_valid & ready_q;
    out_hs = valid_q & output_ready;

    take_new = 1'b0;
    if (count_q == '0) begin
      take_new = 1'b1;
    end else begin
`ifdef ARGMAX_TIE_LAST_EN
      take_new = ($signed(input_data) >= $signed(run_max_q));
`else
      take_new = ($signed(input_data) > $signed(run_max_q));
`endif
    end

    cand_max = take_new ? input_data : run_max_q;
    cand_idx = take_new ? count_q    : run_idx_q;
  end

  // Next-state logic. In COLLECT, input_ready is requested high every
  // cycle. That makes it rise on the first edge after reset release. The
  // result registers load only when DONE is entered, so they keep the
  // previous result while the next vector is being collected.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    out_max_d = out_max_q;
    out_idx_d = out_idx_q;

    case (state_q)
      COLLECT: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        if (in_hs) begin
          run_max_d = cand_max;
          run_idx_d = cand_idx;
          if (count_q == LAST_IDX) begin
            count_d   = '0;
            ready_d   = 1'b0;
            valid_d   = 1'b1;
            out_max_d = cand_max;
            out_idx_d = cand_idx;
            state_d   = DONE;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        ready_d = 1'b0;
        valid_d = 1'b1;
        if (out_hs) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
        count_d = '0;
        ready_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register. Reset drops any partial vector or pending result at
  // once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      run_max_q <= '0;
      run_idx_q <= '0;
      out_max_q <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      out_max_q <= out_max_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign input_ready  = ready_q;
  assign output_valid = valid_q;
  assign output_index = out_idx_q;
  assign output_max   = out_max_q;

endmodule

// File: tb/tb_argmax_stream_m_t.sv
// ---------------------------------------------------------------------------
// tb_argmax_stream_m_t
//
// Self-checking bench for argmax_stream_m_t with M=16 and T=16. It uses
// directed and random vectors. Expected results come from a reference
// argmax over whole vectors. The tie rule follows ARGMAX_TIE_LAST_EN.
// ---------------------------------------------------------------------------
module tb_argmax_stream_m_t;

  localparam int M     = 16;
  localparam int T     = 16;
  localparam int IDX_W = 4;

  typedef logic [T-1:0] vec_t [M];

  logic             clk          = 1'b0;
  logic             reset        = 1'b1;
  logic             input_valid  = 1'b0;
  logic [T-1:0]     input_data   = '0;
  logic             output_ready = 1'b0;
  logic             input_ready;
  logic             output_valid;
  logic [IDX_W-1:0] output_index;
  logic [T-1:0]     output_max;

  int n_checks  = 0;
  int n_errors  = 0;
  int hs_count  = 0;
  logic pre_valid = 1'b0;

  argmax_stream_m_t #(.M(M), .T(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_index (output_index),
    .output_max   (output_max)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Count every element the block actually consumes
  always @(posedge clk) begin
    if (input_valid && input_ready) hs_count <= hs_count + 1;
  end

  // Stop a run that hangs
  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: observed=hang expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  // Reference: find the largest value, then choose its first occurrence
  // (or its last occurrence in tie-last mode)
  function automatic void ref_argmax(input vec_t v, output int idx, output int mx);
    mx = int'($signed(v[0]));
    for (int i = 1; i < M; i++) begin
      if (int'($signed(v[i])) > mx) mx = int'($signed(v[i]));
    end
    idx = -1;
    for (int i = 0; i < M; i++) begin
      if (int'($signed(v[i])) == mx) begin
`ifdef ARGMAX_TIE_LAST_EN
        idx = i;
`else
        if (idx < 0) idx = i;
`endif
      end
    end
  endfunction

  task automatic check_output(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Send one vector from negedge to negedge, with random valid gaps of up
  // to gap_max cycles. On return we are at the negedge after the last
  // handshake.
  task automatic apply_stimulus(input vec_t v, input int gap_max);
    for (int i = 0; i < M; i++) begin
      int  gaps;
      int  tries;
      logic ok;
      logic done;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      input_valid = 1'b0;
      repeat (gaps) @(negedge clk);
      input_valid = 1'b1;
      input_data  = v[i];
      done  = 1'b0;
      tries = 0;
      while (!done && tries < 100) begin
        ok        = input_ready;
        pre_valid = output_valid;
        @(posedge clk);
        @(negedge clk);
        if (ok) done = 1'b1;
        tries++;
      end
      if (!done) check_output("accept_timeout", 0, 1);
    end
    input_valid = 1'b0;
  endtask

  // Wait for a result and compare it with the reference. Then complete the
  // output handshake and check that the block reopens its input.
  task automatic collect_result(input string tag, input vec_t v);
    int   idx;
    int   mx;
    int   tries;
    logic save_ready;
    ref_argmax(v, idx, mx);
    tries = 0;
    while (!output_valid && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    check_output({tag, "_valid"}, int'(output_valid), 1);
    check_output({tag, "_index"}, int'(output_index), idx);
    check_output({tag, "_max"}, int'($signed(output_max)), mx);
    save_ready   = output_ready;
    output_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output({tag, "_valid_drop"}, int'(output_valid), 0);
    check_output({tag, "_ready_back"}, int'(input_ready), 1);
    output_ready = save_ready;
  endtask

  initial begin
    vec_t v;
    int   hs_before;
    int   idx;
    int   mx;

    // Reset values while reset is held, and input_ready after release
    repeat (2) @(negedge clk);
    check_output("rst_ready", int'(input_ready), 0);
    check_output("rst_valid", int'(output_valid), 0);
    check_output("rst_index", int'(output_index), 0);
    check_output("rst_max", int'(output_max), 0);
    reset = 1'b0;
    #1;
    check_output("rel_ready_low", int'(input_ready), 0);
    @(negedge clk);
    check_output("rel_ready_high", int'(input_ready), 1);

    // Ascending values with output_ready tied high, plus result latency
    $display("[TB] ascending vector");
    output_ready = 1'b1;
    for (int i = 0; i < M; i++) v[i] = T'(i);
    apply_stimulus(v, 0);
    check_output("asc_valid_in_last_hs_cycle", int'(pre_valid), 0);
    check_output("asc_latency", int'(output_valid), 1);
    check_output("asc_index_const", int'(output_index), 15);
    check_output("asc_max_const", int'($signed(output_max)), 15);
    collect_result("asc", v);

    // Negative values; the largest is -3 at index 1
    $display("[TB] negative vector");
    for (int i = 0; i < M; i++) v[i] = T'(-128);
    v[0] = T'(-5);
    v[1] = T'(-3);
    v[2] = T'(-100);
    apply_stimulus(v, 0);
    check_output("neg_index_const", int'(output_index), 1);
    collect_result("neg", v);

    // Every element is the most negative value
    $display("[TB] all-minimum vector");
    for (int i = 0; i < M; i++) v[i] = 16'h8000;
    apply_stimulus(v, 0);
`ifdef ARGMAX_TIE_LAST_EN
    check_output("min_index_const", int'(output_index), 15);
`else
    check_output("min_index_const", int'(output_index), 0);
`endif
    collect_result("min", v);

    // Tie: 7 at index 2 and index 9
    $display("[TB] tie vector");
    for (int i = 0; i < M; i++) v[i] = '0;
    v[2] = T'(7);
    v[9] = T'(7);
    apply_stimulus(v, 0);
`ifdef ARGMAX_TIE_LAST_EN
    check_output("tie_index_const", int'(output_index), 9);
`else
    check_output("tie_index_const", int'(output_index), 2);
`endif
    collect_result("tie", v);

    // Backpressure: result held for 10 cycles while input_valid stays high
    $display("[TB] backpressure");
    output_ready = 1'b0;
    for (int i = 0; i < M; i++) v[i] = T'(100 + ((i * 5) % 16));
    apply_stimulus(v, 1);
    ref_argmax(v, idx, mx);
    hs_before   = hs_count;
    input_valid = 1'b1;
    input_data  = 16'h7fff;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_output("bp_ready_low", int'(input_ready), 0);
      check_output("bp_valid_high", int'(output_valid), 1);
      check_output("bp_index_hold", int'(output_index), idx);
      check_output("bp_max_hold", int'($signed(output_max)), mx);
    end
    check_output("bp_no_consume", hs_count - hs_before, 0);
    input_valid = 1'b0;
    collect_result("bp", v);
    for (int i = 0; i < M; i++) v[i] = T'(50 - i);
    apply_stimulus(v, 0);
    collect_result("bp_next", v);

    // Three random vectors with random gaps; exactly M handshakes each
    $display("[TB] random vectors");
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < M; i++) begin
        if (n == 1) v[i] = T'($urandom_range(0, 3));
        else        v[i] = T'($urandom);
      end
      if (n == 2) v[$urandom_range(0, M - 1)] = 16'h8000;
      hs_before = hs_count;
      apply_stimulus(v, 3);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      collect_result($sformatf("rnd%0d", n), v);
      check_output($sformatf("rnd%0d_hs_count", n), hs_count - hs_before, M);
    end

    // Reset mid-vector: the partial vector is discarded
    $display("[TB] reset mid-vector");
    input_valid = 1'b1;
    input_data  = T'(30000);
    repeat (5) @(negedge clk);
    input_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("rstmid_ready", int'(input_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("rstmid_ready_back", int'(input_ready), 1);
    for (int i = 0; i < M; i++) v[i] = T'(i == 3 ? 20 : -i);
    apply_stimulus(v, 0);
    collect_result("rstmid", v);

    // Reset in DONE: the pending result is dropped at once
    $display("[TB] reset in DONE");
    output_ready = 1'b0;
    for (int i = 0; i < M; i++) v[i] = T'(i + 1);
    apply_stimulus(v, 0);
    check_output("rstdone_pending", int'(output_valid), 1);
    #2 reset = 1'b1;
    #1;
    check_output("rstdone_valid", int'(output_valid), 0);
    check_output("rstdone_index", int'(output_index), 0);
    check_output("rstdone_max", int'(output_max), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("rstdone_ready_back", int'(input_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
